// File: rtl/segreader.sv
// segreader: samples seven active-low segment lines, waits for the pattern to settle,
// and reports the matching 3-bit digit code through a VALID/ACK handshake.
module segreader #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic SEGA,
  input  logic SEGB,
  input  logic SEGC,
  input  logic SEGD,
  input  logic SEGE,
  input  logic SEGF,
  input  logic SEGG,
  input  logic ACK,
  output logic A,
  output logic B,
  output logic C,
  output logic VALID,
  output logic ERR,
  output logic OVR
);

  typedef enum logic {
    SETTLE = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam logic [7:0] RUN_MAX  = 8'(STABLE_CYCLES);
  localparam logic [7:0] RUN_LAST = 8'(STABLE_CYCLES - 1);

  logic [6:0] seg_pins;
  logic [6:0] s1_q;
  logic [6:0] s2_q;
  logic [1:0] fill_q;
  logic [7:0] run_q;
  logic [7:0] run_d;
  state_e     state_q;
  logic [6:0] last_q;
  logic       last_ok_q;
  logic [2:0] code_q;
  logic       err_q;
  logic       valid_q;
  logic       ovr_q;

  logic       s2_change;
  logic       accept;
  logic       report;
  logic [2:0] dec_code;
  logic       dec_err;

  assign seg_pins = {SEGA, SEGB, SEGC, SEGD, SEGE, SEGF, SEGG};

  // Until the synchronizer has been refilled after reset, S2 still holds the reset
  // value rather than a pin sample, so those loads count as changes.
  always_comb begin
    // NOTE: every signal written here gets a value before any branch, so no latch is inferred.
    s2_change = (s1_q != s2_q) || !fill_q[1];
    run_d     = run_q;
    if (s2_change) begin
      run_d = 8'd0;
    end else if (run_q != RUN_MAX) begin
      run_d = run_q + 8'd1;
    end
    accept = (state_q == SETTLE) && !s2_change && (run_q == RUN_LAST);
    report = accept && (!last_ok_q || (s2_q != last_q));
  end

  always_comb begin
    dec_err  = 1'b0;
    dec_code = 3'd0;
    unique case (s2_q)
      7'b1111111: dec_code = 3'd0;
      7'b1001111: dec_code = 3'd1;
      7'b0010010: dec_code = 3'd2;
      7'b0000110: dec_code = 3'd3;
      7'b1001100: dec_code = 3'd4;
      7'b0100100: dec_code = 3'd5;
      7'b0100000: dec_code = 3'd6;
      7'b0001111: dec_code = 3'd7;
      default:    dec_err  = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
    if (RST) begin
      s1_q      <= '1;
      s2_q      <= '1;
      fill_q    <= '0;
      run_q     <= '0;
      state_q   <= SETTLE;
      last_q    <= '1;
      last_ok_q <= 1'b0;
      code_q    <= '0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      s1_q   <= seg_pins;
      s2_q   <= s1_q;
      fill_q <= {fill_q[0], 1'b1};
      run_q  <= run_d;

      unique case (state_q)
        SETTLE: if (accept)    state_q <= LOCKED;
        LOCKED: if (s2_change) state_q <= SETTLE;
      endcase

      // A fresh report wins over ACK; only an unacknowledged overwrite marks overrun.
      if (report) begin
        code_q    <= dec_code;
        err_q     <= dec_err;
        valid_q   <= 1'b1;
        last_q    <= s2_q;
        last_ok_q <= 1'b1;
        if (valid_q && !ACK) ovr_q <= 1'b1;
      end else if (valid_q && ACK) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign {A, B, C} = code_q;
  assign VALID     = valid_q;
  assign ERR       = err_q;
  assign OVR       = ovr_q;

endmodule

// File: tb/tb_segreader.sv
// Self-checking bench for segreader: three instances (STABLE_CYCLES 1, 4, 255) share the
// pins and are compared every cycle against a sample-history model, plus literal checks.
module tb_segreader;

  logic       CLK;
  logic       RST;
  logic       ACK;
  logic [6:0] seg;

  logic [2:0] dut_a, dut_b, dut_c, dut_valid, dut_err, dut_ovr;

  int n_checks = 0;
  int n_errors = 0;

  int NS [3] = '{1, 4, 255};
  logic [6:0] legal [8] = '{7'b1111111, 7'b1001111, 7'b0010010, 7'b0000110,
                            7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111};

  segreader #(.STABLE_CYCLES(1)) u_n1 (
    .CLK(CLK), .RST(RST),
    .SEGA(seg[6]), .SEGB(seg[5]), .SEGC(seg[4]), .SEGD(seg[3]),
    .SEGE(seg[2]), .SEGF(seg[1]), .SEGG(seg[0]), .ACK(ACK),
    .A(dut_a[0]), .B(dut_b[0]), .C(dut_c[0]),
    .VALID(dut_valid[0]), .ERR(dut_err[0]), .OVR(dut_ovr[0])
  );

  segreader #(.STABLE_CYCLES(4)) u_n4 (
    .CLK(CLK), .RST(RST),
    .SEGA(seg[6]), .SEGB(seg[5]), .SEGC(seg[4]), .SEGD(seg[3]),
    .SEGE(seg[2]), .SEGF(seg[1]), .SEGG(seg[0]), .ACK(ACK),
    .A(dut_a[1]), .B(dut_b[1]), .C(dut_c[1]),
    .VALID(dut_valid[1]), .ERR(dut_err[1]), .OVR(dut_ovr[1])
  );

  segreader #(.STABLE_CYCLES(255)) u_n255 (
    .CLK(CLK), .RST(RST),
    .SEGA(seg[6]), .SEGB(seg[5]), .SEGC(seg[4]), .SEGD(seg[3]),
    .SEGE(seg[2]), .SEGF(seg[1]), .SEGG(seg[0]), .ACK(ACK),
    .A(dut_a[2]), .B(dut_b[2]), .C(dut_c[2]),
    .VALID(dut_valid[2]), .ERR(dut_err[2]), .OVR(dut_ovr[2])
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: pins sampled at every post-reset edge; a pattern is accepted once it has been
  // sampled STABLE_CYCLES+1 times in a row, one edge after the last of those samples.
  logic [6:0] hist [$];
  bit         armed = 0;
  bit         m_valid [3];
  bit         m_err [3];
  bit         m_ovr [3];
  bit         m_last_ok [3];
  logic [2:0] m_code [3];
  logic [6:0] m_last [3];

  function automatic int lookup(input logic [6:0] p);
    for (int i = 0; i < 8; i++) if (legal[i] == p) return i;
    return -1;
  endfunction

  task automatic model_step();
    int n;
    int base;
    int idx;
    bit acc;
    if (RST) begin
      hist.delete();
      for (int i = 0; i < 3; i++) begin
        m_valid[i] = 0; m_err[i] = 0; m_ovr[i] = 0; m_last_ok[i] = 0;
        m_code[i] = 3'd0; m_last[i] = 7'h7f;
      end
      armed = 1;
      return;
    end
    hist.push_back(seg);
    n = hist.size();
    for (int i = 0; i < 3; i++) begin
      acc  = 0;
      base = n - 2 - NS[i];
      if (base >= 0) begin
        acc = 1;
        for (int j = base + 1; j <= n - 2; j++) if (hist[j] != hist[base]) acc = 0;
        if (base > 0 && hist[base-1] == hist[base]) acc = 0;
      end
      if (acc && (!m_last_ok[i] || hist[base] != m_last[i])) begin
        if (m_valid[i] && !ACK) m_ovr[i] = 1;
        idx          = lookup(hist[base]);
        m_err[i]     = (idx < 0);
        m_code[i]    = (idx < 0) ? 3'd0 : idx[2:0];
        m_valid[i]   = 1;
        m_last[i]    = hist[base];
        m_last_ok[i] = 1;
      end else if (ACK && m_valid[i]) begin
        m_valid[i] = 0;
      end
    end
  endtask

  initial forever begin
    @(posedge CLK);
    model_step();
  end

  initial forever begin
    @(negedge CLK);
    if (armed) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("model_valid_n%0d", NS[i]), 32'(dut_valid[i]), 32'(m_valid[i]));
        check($sformatf("model_code_n%0d", NS[i]),
              32'({dut_a[i], dut_b[i], dut_c[i]}), 32'(m_code[i]));
        check($sformatf("model_err_n%0d", NS[i]), 32'(dut_err[i]), 32'(m_err[i]));
        check($sformatf("model_ovr_n%0d", NS[i]), 32'(dut_ovr[i]), 32'(m_ovr[i]));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic expect_out(input string tag, input int d, input logic v,
                            input logic [2:0] code, input logic e, input logic o);
    check({tag, "_valid"}, 32'(dut_valid[d]), 32'(v));
    check({tag, "_code"}, 32'({dut_a[d], dut_b[d], dut_c[d]}), 32'(code));
    check({tag, "_err"}, 32'(dut_err[d]), 32'(e));
    check({tag, "_ovr"}, 32'(dut_ovr[d]), 32'(o));
  endtask

  task automatic ack_pulse();
    ACK = 1'b1;
    tick(1);
    ACK = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    ACK = 1'b0;
    seg = 7'b1111111;

    // Reset, then blank pins: reported once at k+5.
    tick(1);
    expect_out("reset", 1, 1'b0, 3'd0, 1'b0, 1'b0);
    tick(1);
    RST = 1'b0;
    tick(5);
    check("blank_not_yet", 32'(dut_valid[1]), 32'd0);
    tick(1);
    expect_out("blank_report", 1, 1'b1, 3'd0, 1'b0, 1'b0);
    tick(10);
    expect_out("blank_hold", 1, 1'b1, 3'd0, 1'b0, 1'b0);
    ack_pulse();

    // Digit 3, acknowledged one cycle after VALID, then held long.
    seg = 7'b0000110;
    tick(5);
    check("d3_not_yet", 32'(dut_valid[1]), 32'd0);
    tick(1);
    expect_out("d3_report", 1, 1'b1, 3'd3, 1'b0, 1'b0);
    ack_pulse();
    check("d3_acked", 32'(dut_valid[1]), 32'd0);
    tick(50);
    check("d3_no_rereport", 32'(dut_valid[1]), 32'd0);

    // Short glitch is ignored and the restored pattern is not re-reported.
    seg = 7'b1001100;
    tick(6);
    expect_out("d4_report", 1, 1'b1, 3'd4, 1'b0, 1'b0);
    ack_pulse();
    seg = 7'b0100100;
    tick(2);
    seg = 7'b1001100;
    tick(20);
    check("glitch2_ignored", 32'(dut_valid[1]), 32'd0);

    // Six-cycle glitch is long enough: 101, then 100 again.
    seg = 7'b0100100;
    tick(6);
    expect_out("glitch6_report", 1, 1'b1, 3'd5, 1'b0, 1'b0);
    seg = 7'b1001100;
    ACK = 1'b1;
    tick(1);
    ACK = 1'b0;
    check("glitch6_acked", 32'(dut_valid[1]), 32'd0);
    tick(4);
    check("d4_again_not_yet", 32'(dut_valid[1]), 32'd0);
    tick(1);
    expect_out("d4_again", 1, 1'b1, 3'd4, 1'b0, 1'b0);
    ack_pulse();

    // Illegal pattern, then unacknowledged overwrite sets the sticky overrun.
    seg = 7'b1010101;
    tick(6);
    expect_out("illegal", 1, 1'b1, 3'd0, 1'b1, 1'b0);
    seg = 7'b0001111;
    tick(6);
    expect_out("overwrite", 1, 1'b1, 3'd7, 1'b0, 1'b1);
    ack_pulse();
    tick(3);
    expect_out("ovr_sticky", 1, 1'b0, 3'd7, 1'b0, 1'b1);
    seg = 7'b0100000;
    tick(6);
    expect_out("d6_with_ovr", 1, 1'b1, 3'd6, 1'b0, 1'b1);

    // Reset dominates a pending result and ACK on the same edge.
    RST = 1'b1;
    ACK = 1'b1;
    tick(1);
    expect_out("reset_pending", 1, 1'b0, 3'd0, 1'b0, 1'b0);
    RST = 1'b0;
    ACK = 1'b0;
    tick(6);
    expect_out("d6_after_reset", 1, 1'b1, 3'd6, 1'b0, 1'b0);

    // ACK on the exact accept edge: new result, VALID stays, no overrun.
    seg = 7'b1001111;
    tick(5);
    expect_out("pre_ack_accept", 1, 1'b1, 3'd6, 1'b0, 1'b0);
    ACK = 1'b1;
    tick(1);
    ACK = 1'b0;
    expect_out("ack_on_accept", 1, 1'b1, 3'd1, 1'b0, 1'b0);

    // Sweep all legal patterns at STABLE_CYCLES 1 and 255.
    for (int p = 0; p < 8; p++) begin
      ack_pulse();
      seg = legal[p];
      tick(2);
      check($sformatf("sweep_n1_early_%0d", p), 32'(dut_valid[0]), 32'd0);
      tick(1);
      check($sformatf("sweep_n1_valid_%0d", p), 32'(dut_valid[0]), 32'd1);
      check($sformatf("sweep_n1_code_%0d", p), 32'({dut_a[0], dut_b[0], dut_c[0]}), 32'(p));
      tick(253);
      check($sformatf("sweep_n255_early_%0d", p), 32'(dut_valid[2]), 32'd0);
      tick(1);
      check($sformatf("sweep_n255_valid_%0d", p), 32'(dut_valid[2]), 32'd1);
      check($sformatf("sweep_n255_code_%0d", p), 32'({dut_a[2], dut_b[2], dut_c[2]}), 32'(p));
    end

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
